// File: rtl/fft_stage_feeder.sv
// First 16-point FFT stage: collects a frame of Q8.8 samples and replays it as
// eight (x[n], x[n+8]) butterfly pairs with their W16^n twiddles in Q16.16.
`timescale 1ns/1ps
module fft_stage_feeder #(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned DOUT_W = 32,
  parameter int unsigned NPT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic [DIN_W-1:0]  fir_d,
  output logic              valid,
  output logic [DOUT_W-1:0] real_b,
  output logic [DOUT_W-1:0] imag_b,
  output logic [DOUT_W-1:0] real_a,
  output logic [DOUT_W-1:0] imag_a,
  output logic [DOUT_W-1:0] Real_coff,
  output logic [DOUT_W-1:0] Imag_coff,
  output logic [2:0]        pair_idx
);

  localparam int unsigned CNT_W  = $clog2(NPT);
  localparam int unsigned HALF   = NPT / 2;
  localparam int unsigned PAIR_W = $clog2(HALF);
  localparam int unsigned EXT_W  = DOUT_W - DIN_W - 8;

  typedef enum logic {IDLE, DRAIN} state_e;

  logic [DIN_W-1:0]  sr_q   [NPT-1];
  logic [DIN_W-1:0]  hold_q [NPT];
  logic [CNT_W-1:0]  cnt_q;
  logic              frame_done_c;

  state_e            state_q, state_d;
  logic [PAIR_W-1:0] n_q, n_d;
  logic              valid_q, valid_d;
  logic [DOUT_W-1:0] real_b_q, real_b_d, real_a_q, real_a_d;
  logic [DOUT_W-1:0] rcoef_q, rcoef_d, icoef_q, icoef_d;
  logic [PAIR_W-1:0] pidx_q, pidx_d;

  function automatic logic [DOUT_W-1:0] ext(input logic [DIN_W-1:0] d);
    return {{EXT_W{d[DIN_W-1]}}, d, 8'h00};
  endfunction

  function automatic logic [31:0] rom_re(input logic [2:0] n);
    case (n)
      3'd0:    return 32'h0001_0000;
      3'd1:    return 32'h0000_EC83;
      3'd2:    return 32'h0000_B504;
      3'd3:    return 32'h0000_61F7;
      3'd4:    return 32'h0000_0000;
      3'd5:    return 32'hFFFF_9E09;
      3'd6:    return 32'hFFFF_4AFB;
      default: return 32'hFFFF_137D;
    endcase
  endfunction

  function automatic logic [31:0] rom_im(input logic [2:0] n);
    case (n)
      3'd0:    return 32'h0000_0000;
      3'd1:    return 32'hFFFF_9E09;
      3'd2:    return 32'hFFFF_4AFB;
      3'd3:    return 32'hFFFF_137D;
      3'd4:    return 32'hFFFF_0000;
      3'd5:    return 32'hFFFF_137D;
      3'd6:    return 32'hFFFF_4AFB;
      default: return 32'hFFFF_9E09;
    endcase
  endfunction

  assign frame_done_c = fir_valid && (cnt_q == CNT_W'(NPT - 1));

  // Fill path: oldest sample sits at sr_q[0]; the 16th sample bypasses the shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '{default: '0};
      hold_q <= '{default: '0};
      cnt_q  <= '0;
    end else if (fir_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
      for (int unsigned i = 0; i < NPT - 2; i++) sr_q[i] <= sr_q[i+1];
      sr_q[NPT-2] <= fir_d;
      if (frame_done_c) begin
        for (int unsigned i = 0; i < NPT - 1; i++) hold_q[i] <= sr_q[i];
        hold_q[NPT-1] <= fir_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      valid_q  <= 1'b0;
      real_b_q <= '0;
      real_a_q <= '0;
      rcoef_q  <= '0;
      icoef_q  <= '0;
      pidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      valid_q  <= valid_d;
      real_b_q <= real_b_d;
      real_a_q <= real_a_d;
      rcoef_q  <= rcoef_d;
      icoef_q  <= icoef_d;
      pidx_q   <= pidx_d;
    end
  end

  // Drain sequencer: one pair per cycle, data holds when idle.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    valid_d  = 1'b0;
    real_b_d = real_b_q;
    real_a_d = real_a_q;
    rcoef_d  = rcoef_q;
    icoef_d  = icoef_q;
    pidx_d   = pidx_q;
    case (state_q)
      IDLE: begin
        if (frame_done_c) begin
          state_d = DRAIN;
          n_d     = '0;
        end
      end
      DRAIN: begin
        valid_d  = 1'b1;
        real_b_d = ext(hold_q[CNT_W'(n_q)]);
        real_a_d = ext(hold_q[CNT_W'(n_q) + CNT_W'(HALF)]);
        rcoef_d  = DOUT_W'(rom_re(3'(n_q)));
        icoef_d  = DOUT_W'(rom_im(3'(n_q)));
        pidx_d   = n_q;
        n_d      = n_q + PAIR_W'(1);
        if (n_q == PAIR_W'(HALF - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid     = valid_q;
  assign real_b    = real_b_q;
  assign real_a    = real_a_q;
  assign imag_b    = '0;
  assign imag_a    = '0;
  assign Real_coff = rcoef_q;
  assign Imag_coff = icoef_q;
  assign pair_idx  = 3'(pidx_q);

  // A frame can never complete while the previous one is still draining.
  assert property (@(posedge clk) disable iff (!rst) !(frame_done_c && state_q == DRAIN));

endmodule
